uart_program_loader: RTL and testbench

- Downstream of the UART receiver, upstream of the CPU's 32x8 instruction/data memory.
- After a Load pulse, consumes received bytes in a framed format: length byte, N payload bytes, checksum byte.
- Writes the payload sequentially into memory starting at address 0.
- Holds the CPU (Cpu_hold) until a complete, valid program has been written, then releases it.

---
 rtl/uart_program_loader.sv | 176 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Receives a framed program from the UART receiver and writes it into the
//   CPU's instruction/data memory, holding the CPU until the image is verified.
//   Frame: length byte N (1..MEM_DEPTH), N payload bytes, checksum byte
//   (8-bit sum of payload). The payload is written to addresses 0..N-1.
//
// Ports:
//   Clk       in   system clock, rising edge
//   Reset     in   asynchronous active-low reset
//   Load      in   single-cycle start/restart request (highest priority)
//   Rx_data   in   received byte, qualified by Rx_valid
//   Rx_valid  in   one-cycle strobe per received byte
//   Rx_fe     in   frame error flag, qualified by Rx_valid
//   Mem_we    out  memory write strobe, one cycle after an accepted payload byte
//   Mem_addr  out  memory write address
//   Mem_wdata out  memory write data
//   Cpu_hold  out  1 = CPU held at PC 0 (everywhere except DONE)
//   Done      out  program loaded and checksum verified (level)
//   Err       out  load failed (level)
//   Err_code  out  00 none, 01 frame error, 10 bad length/checksum, 11 timeout
module uart_program_loader #(
  parameter int unsigned MEM_DEPTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Load,
  input  logic [7:0]                   Rx_data,
  input  logic                         Rx_valid,
  input  logic                         Rx_fe,
  output logic                         Mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] Mem_addr,
  output logic [7:0]                   Mem_wdata,
  output logic                         Cpu_hold,
  output logic                         Done,
  output logic                         Err,
  output logic [1:0]                   Err_code
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  // Length/count need one extra bit so N = MEM_DEPTH is representable.
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    E_NONE    = 2'b00,
    E_FRAME   = 2'b01,
    E_FORMAT  = 2'b10,
    E_TIMEOUT = 2'b11
  } err_t;

  state_t          state_q, state_d;
  err_t            err_q, err_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   count_q, count_d;
  logic [LW-1:0]   count_inc;
  logic [7:0]      csum_q, csum_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;

  assign count_inc = count_q + 1'b1;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      err_q   <= E_NONE;
      len_q   <= '0;
      count_q <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    count_d = count_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (Load) begin
      // Any byte arriving with Load is dropped.
      state_d = S_LEN;
      err_d   = E_NONE;
      count_d = '0;
      csum_d  = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        S_LEN, S_DATA, S_CSUM: begin
          if (Rx_valid) begin
            tmo_d = '0;
            if (Rx_fe) begin
              state_d = S_ERROR;
              err_d   = E_FRAME;
            end else begin
              case (state_q)
                S_LEN: begin
                  if (Rx_data == 8'd0 || Rx_data > 8'(MEM_DEPTH)) begin
                    state_d = S_ERROR;
                    err_d   = E_FORMAT;
                  end else begin
                    len_d   = Rx_data[LW-1:0];
                    state_d = S_DATA;
                  end
                end
                S_DATA: begin
                  we_d    = 1'b1;
                  addr_d  = count_q[AW-1:0];
                  wdata_d = Rx_data;
                  csum_d  = csum_q + Rx_data;
                  count_d = count_inc;
                  if (count_inc == len_q) state_d = S_CSUM;
                end
                S_CSUM: begin
                  if (Rx_data != csum_q) begin
                    state_d = S_ERROR;
                    err_d   = E_FORMAT;
                  end else begin
                    state_d = S_DONE;
                  end
                end
                default: ;
              endcase
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            // TIMEOUT_CYCLES consecutive idle cycles since the last byte/Load.
            state_d = S_ERROR;
            err_d   = E_TIMEOUT;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: tmo_d = '0;
      endcase
    end
  end

  assign Mem_we    = we_q;
  assign Mem_addr  = addr_q;
  assign Mem_wdata = wdata_q;
  assign Done      = (state_q == S_DONE);
  assign Err       = (state_q == S_ERROR);
  assign Cpu_hold  = (state_q != S_DONE);
  assign Err_code  = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;

  logic       Clk      = 1'b0;
  logic       Reset    = 1'b0;
  logic       Load     = 1'b0;
  logic [7:0] Rx_data  = 8'h00;
  logic       Rx_valid = 1'b0;
  logic       Rx_fe    = 1'b0;
  logic       Mem_we;
  logic [4:0] Mem_addr;
  logic [7:0] Mem_wdata;
  logic       Cpu_hold;
  logic       Done;
  logic       Err;
  logic [1:0] Err_code;

  uart_program_loader #(
    .MEM_DEPTH      (32),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Rx_data   (Rx_data),
    .Rx_valid  (Rx_valid),
    .Rx_fe     (Rx_fe),
    .Mem_we    (Mem_we),
    .Mem_addr  (Mem_addr),
    .Mem_wdata (Mem_wdata),
    .Cpu_hold  (Cpu_hold),
    .Done      (Done),
    .Err       (Err),
    .Err_code  (Err_code)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  fd[$];
  bit  ff[$];

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge Clk) begin
    if (Mem_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", Mem_addr, Mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (Mem_addr !== 5'(e.addr) || Mem_wdata !== 8'(e.data)) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   Mem_addr, Mem_wdata, e.addr, e.data);
        end
      end
    end else if (Mem_we !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL mem_we_unknown: got %b, required 0/1", Mem_we);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe);
    Rx_valid = 1'b1;
    Rx_data  = b;
    Rx_fe    = fe;
    tick();
    Rx_valid = 1'b0;
    Rx_fe    = 1'b0;
    Rx_data  = $urandom_range(255);
  endtask

  task automatic do_load();
    Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  // Reference model: interprets a byte stream as a frame and predicts the
  // writes and the final status. Incomplete frames predict "still loading".
  task automatic model_frame(input int d[$], input bit f[$],
                             output int e_done, output int e_err, output int e_code);
    int n, sum;
    e_done = 0; e_err = 0; e_code = 0;
    if (d.size() == 0) return;
    if (f[0]) begin e_err = 1; e_code = 1; return; end
    n = d[0];
    if (n < 1 || n > 32) begin e_err = 1; e_code = 2; return; end
    sum = 0;
    for (int i = 1; i <= n; i++) begin
      if (i >= d.size()) return;
      if (f[i]) begin e_err = 1; e_code = 1; return; end
      exp_q.push_back('{addr: i - 1, data: d[i]});
      sum = (sum + d[i]) % 256;
    end
    if (n + 1 >= d.size()) return;
    if (f[n + 1])          begin e_err = 1; e_code = 1; end
    else if (d[n + 1] != sum) begin e_err = 1; e_code = 2; end
    else                   e_done = 1;
  endtask

  task automatic check_status(input string name, input int ed, input int ee, input int ec);
    check({name, ".done"},     32'(Done),       32'(ed));
    check({name, ".err"},      32'(Err),        32'(ee));
    check({name, ".err_code"}, 32'(Err_code),   32'(ec));
    check({name, ".cpu_hold"}, 32'(Cpu_hold),   (ed != 0) ? 32'd0 : 32'd1);
    check({name, ".pending"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_frame(input string name, input bit with_load, input int max_gap);
    int ed, ee, ec;
    if (with_load) do_load();
    model_frame(fd, ff, ed, ee, ec);
    foreach (fd[i]) begin
      send_byte(8'(fd[i]), ff[i]);
      repeat ($urandom_range(max_gap)) tick();
    end
    tick();
    tick();
    check_status(name, ed, ee, ec);
  endtask

  task automatic set_frame(input int d[$]);
    fd = d;
    ff = {};
    foreach (d[i]) ff.push_back(1'b0);
  endtask

  initial begin
    int ed, ee, ec, j, n, sum;

    // Reset state
    repeat (3) tick();
    check("rst.mem_we",    32'(Mem_we),    32'd0);
    check("rst.mem_addr",  32'(Mem_addr),  32'd0);
    check("rst.mem_wdata", 32'(Mem_wdata), 32'd0);
    check_status("rst", 0, 0, 0);
    Reset = 1'b1;
    tick();

    // Bytes in IDLE are ignored
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    tick();
    check_status("idle_ignore", 0, 0, 0);

    // Directed frames
    set_frame('{8'h03, 8'h11, 8'h22, 8'h33, 8'h66});
    run_frame("good3", 1'b1, 1);
    set_frame('{8'h02, 8'hFF, 8'h02, 8'h02});
    run_frame("bad_csum", 1'b1, 1);
    set_frame('{8'h00});
    run_frame("len0", 1'b1, 0);
    set_frame('{8'h21});
    run_frame("len33", 1'b1, 0);
    fd = {}; ff = {};
    fd.push_back(32); ff.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin fd.push_back(1); ff.push_back(1'b0); end
    fd.push_back(8'h20); ff.push_back(1'b0);
    run_frame("len32", 1'b1, 0);
    set_frame('{8'h02, 8'hAA, 8'h55});
    ff[2] = 1'b1;
    run_frame("frame_err", 1'b1, 1);

    // Load coinciding with a byte: the byte (an illegal length) is dropped
    do_load();
    Load = 1'b1; Rx_valid = 1'b1; Rx_data = 8'h00;
    tick();
    Load = 1'b0; Rx_valid = 1'b0;
    tick();
    check_status("load_collide", 0, 0, 0);
    set_frame('{8'h01, 8'h5A, 8'h5A});
    run_frame("after_collide", 1'b0, 0);

    // Timeout after two bytes
    do_load();
    set_frame('{8'h04, 8'h10});
    model_frame(fd, ff, ed, ee, ec);
    send_byte(8'h04, 1'b0);
    send_byte(8'h10, 1'b0);
    j = 0;
    while (Err !== 1'b1 && j < 5000) begin tick(); j++; end
    n_cmp++;
    if (j < 4095 || j > 4097) begin
      n_err++;
      $display("FAIL timeout_cycles: got %0d idle cycles, required about 4096", j);
    end
    check_status("timeout", 0, 1, 3);

    // Reset mid-DATA
    do_load();
    set_frame('{8'h05, 8'hA1, 8'hB2});
    model_frame(fd, ff, ed, ee, ec);
    foreach (fd[i]) send_byte(8'(fd[i]), 1'b0);
    tick();
    Reset = 1'b0;
    #1;
    check("rst_mid.mem_we",    32'(Mem_we),    32'd0);
    check("rst_mid.mem_addr",  32'(Mem_addr),  32'd0);
    check("rst_mid.mem_wdata", 32'(Mem_wdata), 32'd0);
    check_status("rst_mid", 0, 0, 0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    Reset = 1'b1;
    send_byte(8'hE5, 1'b0);
    tick();
    check_status("rst_after", 0, 0, 0);

    // Randomized frames
    for (int t = 0; t < 40; t++) begin
      fd = {}; ff = {};
      if ($urandom_range(9) == 0)
        n = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(255, 33));
      else
        n = $urandom_range(32, 1);
      fd.push_back(n); ff.push_back(1'b0);
      if (n >= 1 && n <= 32) begin
        sum = 0;
        for (int i = 0; i < n; i++) begin
          fd.push_back($urandom_range(255));
          ff.push_back(1'b0);
          sum = (sum + fd[$]) % 256;
        end
        if ($urandom_range(4) == 0) sum = sum ^ int'($urandom_range(255, 1));
        fd.push_back(sum); ff.push_back(1'b0);
      end
      if ($urandom_range(9) == 0) ff[$urandom_range(fd.size() - 1)] = 1'b1;
      repeat ($urandom_range(2)) begin fd.push_back($urandom_range(255)); ff.push_back(1'b0); end
      run_frame($sformatf("rand%0d", t), 1'b1, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
